flag_stack_register: RTL
========================

# flag_stack_register

Parametrised condition-flag register for the pipelined datapath. It holds FLAG_W condition flags (default order {C,V,N,Z}) with per-flag write enables, and adds a DEPTH-entry hardware save/restore stack for interrupt and exception entry/exit. It sits after the alu_shifter stage; branch-resolution logic reads its outputs.

## Interface
- FLAG_W, 4: number of flags; bit 0 = Z, 1 = N, 2 = V, 3 = C; valid range 1–16.
- DEPTH, 4: save-stack entries; power of two, 2–16.
- SP_W, $clog2(DEPTH+1): width of the occupancy count.

- clk  in  1  clock; all state updates on rising edge.
- clrn  in  1  synchronous active-low reset, sampled on rising edge of clk.
- wr_en  in  FLAG_W  per-flag write enable; bit i updates live flag i.
- flags_in  in  FLAG_W  new flag values from the ALU.
- push  in  1  save current live flags onto the stack.
- pop  in  1  restore live flags from the stack top.
- err_clr  in  1  clear the sticky error bits.
- flags  out  FLAG_W  live flag values.
- sp  out  SP_W  stack occupancy, 0..DEPTH.
- full  out  1  sp == DEPTH.
- empty  out  1  sp == 0.
- ovf  out  1  sticky: a push was attempted while full.
- unf  out  1  sticky: a pop was attempted while empty.

## Operation
- Reset (clrn=0 at an edge): flags=0, sp=0, ovf=0, unf=0, full=0, empty=1. Stack contents are don't-care. Reset overrides all other inputs.
- Live update: flags[i] <= flags_in[i] where wr_en[i]=1; other bits hold.
- Push (push=1, pop=0, not full): stack[sp] <= flags as they are *before* this cycle's write, then sp <= sp+1. The masked write still applies to the live flags in the same cycle.
- Pop (pop=1, push=0, not empty): live flags <= stack[sp-1], then sp <= sp-1. Masked write bits overlay the restored value, so the newest data wins per bit.
- Push and pop together: stack and sp are unchanged, ovf/unf are unaffected, and the masked write still applies.
- Push while full: the push is ignored and ovf <= 1. Pop while empty: the pop is ignored, live flags take only the masked write, and unf <= 1.
- err_clr=1 clears ovf and unf. If a new error occurs in the same cycle, setting wins.
- full and empty are decoded from registered sp, with no extra latency.
- Stack storage is a register array indexed by sp. There is no wrap-around, because sp saturates by rule.

## Timing
- All outputs are registered. Latency is 1 cycle from input to flags, sp and error outputs, except as noted under Configuration.
- Push followed by pop on back-to-back cycles returns the exact saved value.
- Reset asserted mid-sequence takes effect at the next edge. The stack is logically emptied.

## Configuration
- FLAG_STACK_BYPASS_EN defined:
  - flags becomes combinational forwarding: for each bit, flags_in[i] if wr_en[i], else the popped top if pop is valid, else the registered value.
  - Consumers see the update in the same cycle.
  - sp, full, empty, ovf and unf remain registered.
- Undefined: flags is purely registered, with 1-cycle latency.

## Test plan
- Reset, then wr_en=4'b1111, flags_in=4'b1010 → next cycle flags=1010. Then wr_en=4'b0001, flags_in=0 → flags=1010.
- flags=0110, push with wr_en=1111, flags_in=1001 → flags=1001, sp=1. Next cycle pop → flags=0110, sp=0, empty=1.
- DEPTH=4: five pushes → sp=4, full=1, ovf=1 after the 5th. err_clr → ovf=0 and sp stays 4.
- From empty, pop → unf=1, flags unchanged. Pop with err_clr in the same cycle → unf=1.
- Pop with wr_en=0001, flags_in=0001, stack top=1110 → flags=1111. Push and pop together → sp unchanged.
- Mid-sequence clrn=0 with sp=3 → next edge sp=0, flags=0. With FLAG_STACK_BYPASS_EN, flags equals flags_in in the same cycle that wr_en is asserted.

Source files
------------

// File: rtl/flag_stack_register_if.sv
// Flag register bus: ALU-side writes, save/restore controls
// and the registered flag/stack status seen by branch logic.
interface flag_stack_register_if #(
    parameter int FLAG_W = 4,
    parameter int DEPTH  = 4,
    parameter int SP_W   = $clog2(DEPTH + 1)
);
    logic [FLAG_W-1:0] wr_en;
    logic [FLAG_W-1:0] flags_in;
    logic              push;
    logic              pop;
    logic              err_clr;
    logic [FLAG_W-1:0] flags;
    logic [SP_W-1:0]   sp;
    logic              full;
    logic              empty;
    logic              ovf;
    logic              unf;

    modport master (
        output wr_en, flags_in, push, pop, err_clr,
        input  flags, sp, full, empty, ovf, unf
    );

    modport slave (
        input  wr_en, flags_in, push, pop, err_clr,
        output flags, sp, full, empty, ovf, unf
    );
endinterface

// File: rtl/flag_stack_register.sv
// Condition-flag register with a DEPTH-entry save/restore stack.
// Optional macro FLAG_STACK_BYPASS_EN forwards next flags combinationally.
module flag_stack_register #(
    parameter int FLAG_W = 4,
    parameter int DEPTH  = 4,
    parameter int SP_W   = $clog2(DEPTH + 1)
) (
    input logic clk,
    input logic clrn,
    flag_stack_register_if.slave bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [FLAG_W-1:0] flags_q, flags_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [FLAG_W-1:0] stack_q [DEPTH];

    logic              full, empty;
    logic              do_push, do_pop;
    logic              push_only, pop_only;
    logic [IDX_W-1:0]  push_idx, top_idx;
    logic [FLAG_W-1:0] top;
    logic [FLAG_W-1:0] base;

    assign full  = (sp_q == SP_W'(DEPTH));
    assign empty = (sp_q == '0);

    // Next-state: stack decisions, then masked write overlays restored flags.
    always_comb begin
        push_only = bus.push & ~bus.pop;
        pop_only  = bus.pop & ~bus.push;
        do_push   = push_only & ~full;
        do_pop    = pop_only & ~empty;
        push_idx  = IDX_W'(sp_q);
        top_idx   = IDX_W'(sp_q - SP_W'(1));
        top       = stack_q[top_idx];
        base      = do_pop ? top : flags_q;
        flags_d   = (base & ~bus.wr_en) | (bus.flags_in & bus.wr_en);
        sp_d      = sp_q;
        if (do_push) sp_d = sp_q + SP_W'(1);
        if (do_pop)  sp_d = sp_q - SP_W'(1);
        ovf_d = (ovf_q & ~bus.err_clr) | (push_only & full);
        unf_d = (unf_q & ~bus.err_clr) | (pop_only & empty);
    end

    // Live flags, occupancy and sticky errors; reset empties the stack.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            flags_q <= '0;
            sp_q    <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            sp_q    <= sp_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Save pre-write live flags at the current top on an accepted push.
    always_ff @(posedge clk) begin
        if (clrn && do_push) stack_q[push_idx] <= flags_q;
    end

`ifdef FLAG_STACK_BYPASS_EN
    assign bus.flags = flags_d;
`else
    assign bus.flags = flags_q;
`endif
    assign bus.sp    = sp_q;
    assign bus.full  = full;
    assign bus.empty = empty;
    assign bus.ovf   = ovf_q;
    assign bus.unf   = unf_q;
endmodule
